// File: rtl/urng_seq_ctrl.sv
// Sequencing controller for the Tausworthe uniform generator: seeds it, discards a
// warm-up run, then packs word pairs into 48-bit u0 / 16-bit u1 uniforms.
module urng_seq_ctrl #(
    parameter int          SEED_CYCLES  = 4,
    parameter int          WARMUP_WORDS = 16,
    parameter logic [31:0] DEF_SEED1    = 32'hfff00000,
    parameter logic [31:0] DEF_SEED2    = 32'hff11118f,
    parameter logic [31:0] DEF_SEED3    = 32'hf111abe0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic [31:0] seed_in1,
    input  logic [31:0] seed_in2,
    input  logic [31:0] seed_in3,
    output logic [31:0] urng_seed1,
    output logic [31:0] urng_seed2,
    output logic [31:0] urng_seed3,
    output logic        urng_reset,
    input  logic [31:0] urng_out,
    input  logic        urng_valid,
    output logic [47:0] u0,
    output logic [15:0] u1,
    output logic        u_valid,
    input  logic        u_ready,
    output logic [15:0] drop_cnt,
    output logic        busy
);

    typedef enum logic [1:0] {ST_IDLE, ST_SEED, ST_WARMUP, ST_RUN} state_t;

    // With no warm-up configured the generator output is usable straight after seeding.
    localparam state_t POST_SEED = (WARMUP_WORDS == 0) ? ST_RUN : ST_WARMUP;

    state_t      state_reg, state_next;
    logic [31:0] cnt_reg, cnt_next;
    logic [31:0] a_reg, a_next;
    logic        phase_reg, phase_next;
    logic [47:0] u0_reg, u0_next;
    logic [15:0] u1_reg, u1_next;
    logic        u_valid_reg, u_valid_next;
    logic [15:0] drop_cnt_reg, drop_cnt_next;
    logic        pair_done;

    logic [31:0] seed_req [3];
    logic [31:0] seed_min [3];
    logic [31:0] def_seed [3];
    logic [31:0] seed_ok  [3];
    logic [31:0] seed_reg [3];
    logic [31:0] seed_next[3];

    assign seed_req[0] = seed_in1;
    assign seed_req[1] = seed_in2;
    assign seed_req[2] = seed_in3;
    assign seed_min[0] = 32'd2;
    assign seed_min[1] = 32'd8;
    assign seed_min[2] = 32'd16;
    assign def_seed[0] = DEF_SEED1;
    assign def_seed[1] = DEF_SEED2;
    assign def_seed[2] = DEF_SEED3;

    // Seeds below each component's minimum would leave the generator degenerate.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sanitise
            assign seed_ok[gi] = (seed_req[gi] < seed_min[gi]) ? def_seed[gi] : seed_req[gi];
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        a_next        = a_reg;
        phase_next    = phase_reg;
        u0_next       = u0_reg;
        u1_next       = u1_reg;
        u_valid_next  = u_valid_reg;
        drop_cnt_next = drop_cnt_reg;
        seed_next     = seed_reg;
        pair_done     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start && !stop) begin
                    seed_next     = seed_ok;
                    drop_cnt_next = 16'd0;
                    cnt_next      = 32'(SEED_CYCLES - 1);
                    phase_next    = 1'b0;
                    state_next    = ST_SEED;
                end
            end
            ST_SEED: begin
                if (cnt_reg == 32'd0) begin
                    cnt_next   = 32'(WARMUP_WORDS);
                    state_next = POST_SEED;
                end else begin
                    cnt_next = cnt_reg - 32'd1;
                end
            end
            ST_WARMUP: begin
                if (urng_valid) begin
                    cnt_next = cnt_reg - 32'd1;
                    if (cnt_reg == 32'd1) begin
                        state_next = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (urng_valid) begin
                    if (!phase_reg) begin
                        a_next     = urng_out;
                        phase_next = 1'b1;
                    end else begin
                        phase_next = 1'b0;
                        pair_done  = 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // The generator cannot stall, so a pair that finds the output occupied is lost.
        if (pair_done) begin
            if (!u_valid_reg || u_ready) begin
                u0_next      = {a_reg, urng_out[31:16]};
                u1_next      = urng_out[15:0];
                u_valid_next = 1'b1;
            end else if (drop_cnt_reg != 16'hffff) begin
                drop_cnt_next = drop_cnt_reg + 16'd1;
            end
        end else if (u_valid_reg && u_ready) begin
            u_valid_next = 1'b0;
        end

        if (stop) begin
            state_next   = ST_IDLE;
            u_valid_next = 1'b0;
            phase_next   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= 32'd0;
            a_reg        <= 32'd0;
            phase_reg    <= 1'b0;
            u0_reg       <= 48'd0;
            u1_reg       <= 16'd0;
            u_valid_reg  <= 1'b0;
            drop_cnt_reg <= 16'd0;
            seed_reg     <= '{default: '0};
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            a_reg        <= a_next;
            phase_reg    <= phase_next;
            u0_reg       <= u0_next;
            u1_reg       <= u1_next;
            u_valid_reg  <= u_valid_next;
            drop_cnt_reg <= drop_cnt_next;
            seed_reg     <= seed_next;
        end
    end

    assign urng_seed1 = seed_reg[0];
    assign urng_seed2 = seed_reg[1];
    assign urng_seed3 = seed_reg[2];
    assign urng_reset = (state_reg == ST_IDLE) || (state_reg == ST_SEED);
    assign busy       = (state_reg != ST_IDLE);
    assign u0         = u0_reg;
    assign u1         = u1_reg;
    assign u_valid    = u_valid_reg;
    assign drop_cnt   = drop_cnt_reg;

endmodule

// File: tb/tb_urng_seq_ctrl.sv
// Directed bench for urng_seq_ctrl: seeding, warm-up discard, pair packing,
// backpressure drops with saturation, stop/start interplay and mid-run reset.
module tb_urng_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset, start, stop;
    logic [31:0] seed_in1, seed_in2, seed_in3;
    logic [31:0] urng_seed1, urng_seed2, urng_seed3;
    logic        urng_reset;
    logic [31:0] urng_out;
    logic        urng_valid;
    logic [47:0] u0;
    logic [15:0] u1;
    logic        u_valid, u_ready;
    logic [15:0] drop_cnt;
    logic        busy;

    int tests_run = 0;
    int tests_failed = 0;
    int valid_seen;

    localparam logic [31:0] DEF1 = 32'hfff00000;
    localparam logic [31:0] DEF2 = 32'hff11118f;
    localparam logic [31:0] DEF3 = 32'hf111abe0;

    urng_seq_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .seed_in1(seed_in1), .seed_in2(seed_in2), .seed_in3(seed_in3),
        .urng_seed1(urng_seed1), .urng_seed2(urng_seed2), .urng_seed3(urng_seed3),
        .urng_reset(urng_reset), .urng_out(urng_out), .urng_valid(urng_valid),
        .u0(u0), .u1(u1), .u_valid(u_valid), .u_ready(u_ready),
        .drop_cnt(drop_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("[TB] ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic feed(input int w);
        urng_out   = 32'(w);
        urng_valid = 1'b1;
        tick();
        urng_valid = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_urng_reset"}, urng_reset, 1'b1);
        check({tag, "_seed1"}, urng_seed1, 32'd0);
        check({tag, "_seed2"}, urng_seed2, 32'd0);
        check({tag, "_seed3"}, urng_seed3, 32'd0);
        check({tag, "_u0"}, u0, 48'd0);
        check({tag, "_u1"}, u1, 16'd0);
        check({tag, "_u_valid"}, u_valid, 1'b0);
        check({tag, "_drop"}, drop_cnt, 16'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0;
        seed_in1 = '0; seed_in2 = '0; seed_in3 = '0;
        urng_out = '0; urng_valid = 1'b0; u_ready = 1'b1;
        @(negedge clk);
        tick(); tick();
        reset = 1'b0;
        check_reset_state("rst");

        // Start with the default seeds: passed unchanged, urng_reset high 4 cycles.
        seed_in1 = DEF1; seed_in2 = DEF2; seed_in3 = DEF3;
        start = 1'b1; tick(); start = 1'b0;
        check("start_busy", busy, 1'b1);
        check("def_seed1", urng_seed1, DEF1);
        check("def_seed2", urng_seed2, DEF2);
        check("def_seed3", urng_seed3, DEF3);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("seed_rst_hi%0d", i), urng_reset, 1'b1);
            tick();
        end
        check("seed_rst_lo", urng_reset, 1'b0);

        // Warm-up discards words 0..15, first pair is 16:17.
        for (int w = 0; w < 18; w++) begin
            feed(w);
            if (w == 16) check("no_valid_before_18", u_valid, 1'b0);
        end
        check("pair1_valid", u_valid, 1'b1);
        check("pair1_u0", u0, {32'd16, 16'h0000});
        check("pair1_u1", u1, 16'h0011);

        // Continuous words, ready high: pair every second cycle, no drops.
        valid_seen = 0;
        for (int w = 18; w < 26; w++) begin
            feed(w);
            if (u_valid) valid_seen++;
            if (w == 19) check("pair2_u0", u0, {32'd18, 16'h0000});
            if (w == 19) check("pair2_u1", u1, 16'h0013);
        end
        check("alt_valid_count", valid_seen, 4);
        check("no_drop", drop_cnt, 16'd0);

        // Hold pair 24:25 while 10 further pairs arrive.
        u_ready = 1'b0;
        for (int w = 26; w < 46; w++) feed(w);
        check("held_u0", u0, {32'd24, 16'h0000});
        check("held_u1", u1, 16'h0019);
        check("held_valid", u_valid, 1'b1);
        check("drop10", drop_cnt, 16'd10);

        // One-cycle ready dip between pairs does not drop.
        u_ready = 1'b1; feed(46);
        check("accept_clears_valid", u_valid, 1'b0);
        feed(47);
        u_ready = 1'b0; feed(48);
        u_ready = 1'b1; feed(49);
        check("dip_u0", u0, {32'd48, 16'h0000});
        check("dip_u1", u1, 16'h0031);
        check("dip_no_drop", drop_cnt, 16'd10);

        // Saturation: preset near the top, block three pairs.
        u_ready = 1'b0;
        force dut.drop_cnt_reg = 16'hfffe;
        tick();
        release dut.drop_cnt_reg;
        tick();
        check("preset_fffe", drop_cnt, 16'hfffe);
        for (int w = 50; w < 56; w++) feed(w);
        check("drop_sat", drop_cnt, 16'hffff);

        // Stop in RUN with u_valid high.
        stop = 1'b1; tick(); stop = 1'b0;
        check("stop_run_busy", busy, 1'b0);
        check("stop_run_urst", urng_reset, 1'b1);
        check("stop_run_valid", u_valid, 1'b0);
        check("stop_run_u0_kept", u0, {32'd48, 16'h0000});
        check("stop_run_drop_kept", drop_cnt, 16'hffff);

        // start + stop together in IDLE: nothing happens.
        seed_in1 = 32'd1; seed_in2 = 32'd7; seed_in3 = 32'd15;
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        check("startstop_busy", busy, 1'b0);
        check("startstop_drop", drop_cnt, 16'hffff);

        // Small seeds replaced; drop count cleared on start.
        start = 1'b1; tick(); start = 1'b0;
        check("small_seed1", urng_seed1, DEF1);
        check("small_seed2", urng_seed2, DEF2);
        check("small_seed3", urng_seed3, DEF3);
        check("start_clears_drop", drop_cnt, 16'd0);
        for (int i = 0; i < 4; i++) tick();
        feed(0); feed(1);
        stop = 1'b1; tick(); stop = 1'b0;
        check("stop_warm_busy", busy, 1'b0);
        check("stop_warm_urst", urng_reset, 1'b1);
        check("stop_warm_valid", u_valid, 1'b0);

        // Boundary seeds pass unchanged; words during SEED are ignored.
        seed_in1 = 32'd2; seed_in2 = 32'd8; seed_in3 = 32'd16;
        u_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        check("edge_seed1", urng_seed1, 32'd2);
        check("edge_seed2", urng_seed2, 32'd8);
        check("edge_seed3", urng_seed3, 32'd16);
        for (int w = 0; w < 22; w++) begin
            feed(w);
            if (w == 20) check("seed_words_ignored", u_valid, 1'b0);
        end
        check("run2_valid", u_valid, 1'b1);
        check("run2_u0", u0, {32'd20, 16'h0000});
        check("run2_u1", u1, 16'h0015);

        // Reset in RUN overrides everything, including a concurrent start.
        start = 1'b1; reset = 1'b1; tick(); start = 1'b0; reset = 1'b0;
        check_reset_state("midrst");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/urng_seq_ctrl.md
# urng_seq_ctrl

Sequencing controller for the Tausworthe uniform generator in the AWGN chain. Loads and sanitises the three seeds, holds the generator in reset while seeding, discards a warm-up run of words, then packs consecutive 32-bit words into the 48-bit u0 / 16-bit u1 uniform pairs consumed by the Box-Muller stage. Downstream uses a valid/ready handshake. The generator cannot stall, so pairs arriving while the output is blocked are dropped and counted.

## Interface
- SEED_CYCLES, 4: cycles urng_reset is held high in SEED (≥1)
- WARMUP_WORDS, 16: valid generator words discarded before RUN (0 allowed)
- DEF_SEED1 / DEF_SEED2 / DEF_SEED3, 32'hfff00000 / 32'hff11118f / 32'hf111abe0: substitute seeds
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  pulse; latch seed_in1..3 and begin sequence (honoured in IDLE only)
- stop  in  1  pulse; abort to IDLE from any state
- seed_in1, seed_in2, seed_in3  in  32 each  requested seeds
- urng_seed1, urng_seed2, urng_seed3  out  32 each  sanitised seeds to generator
- urng_reset  out  1  generator reset, active-high
- urng_out  in  32  generator word
- urng_valid  in  1  generator word valid
- u0  out  48  uniform for log/sqrt path
- u1  out  16  uniform for sin/cos path
- u_valid  out  1  pair valid
- u_ready  in  1  downstream accepts pair
- drop_cnt  out  16  pairs dropped, saturating
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, SEED, WARMUP, RUN.
- IDLE: urng_reset=1. start & !stop → latch seeds, clear drop_cnt, cnt=SEED_CYCLES-1, go SEED. start while busy ignored.
- Seed sanitising at latch: seed1<2 → DEF_SEED1; seed2<8 → DEF_SEED2; seed3<16 → DEF_SEED3 (unsigned compare); otherwise unchanged. urng_seedN hold latched values until next accepted start.
- SEED: urng_reset=1; cnt decrements each cycle; at cnt==0 go WARMUP (cnt=WARMUP_WORDS) or RUN if WARMUP_WORDS==0.
- WARMUP: urng_reset=0; each urng_valid decrements cnt; the word making cnt 0 is discarded, next state RUN.
- RUN: urng_reset=0. phase bit, reset 0. urng_valid with phase=0 → a_reg=urng_out, phase=1. urng_valid with phase=1 → pair complete: u0={a_reg, urng_out[31:16]}, u1=urng_out[15:0]; phase=0.
- Pair load: if !u_valid or (u_valid & u_ready) in completing cycle, load u0/u1, u_valid=1. Otherwise pair dropped, drop_cnt+1, saturating at 16'hffff; held pair unchanged.
- u_valid & u_ready with no completing pair → u_valid=0 next cycle.
- u0/u1 stable while u_valid & !u_ready.
- stop (any state, wins over start): next cycle IDLE, urng_reset=1, u_valid=0, phase=0; u0/u1/drop_cnt retain values.
- urng_valid ignored in IDLE and SEED.

## Timing
- Reset values: state IDLE, urng_reset=1, urng_seed1..3=0, u0=0, u1=0, u_valid=0, drop_cnt=0, busy=0, phase=0.
- start sampled cycle T → busy=1 and urng_seedN valid at T+1; urng_reset high T+1..T+SEED_CYCLES, low from T+SEED_CYCLES+1.
- Pair latency: second word sampled at edge E → u_valid/u0/u1 updated at E (visible following cycle); one-register latency.
- Generator at one word per cycle → max one pair per two cycles; u_ready low for one cycle never causes a drop.
- reset mid-operation overrides everything incl. start/stop; all registers to reset values at that edge.

## Test plan
- Reset, then start with seeds 32'hfff00000/32'hff11118f/32'hf111abe0, SEED_CYCLES=4 → busy=1 next cycle, urng_reset high exactly 4 cycles, seeds passed unchanged.
- Seeds 1/7/15 → urng_seed1..3 = DEF_SEED1..3; seeds 2/8/16 → passed unchanged.
- WARMUP_WORDS=16, generator words 0..N incrementing: first pair = word16:word17 → u0={32'd16,16'h0000}, u1=16'h0011; no u_valid before 18th valid word.
- u_ready tied 1, continuous urng_valid → u_valid on every second cycle, drop_cnt stays 0; u_ready=0 for 10 pairs after first held → first pair held stable, drop_cnt=10.
- Force drop_cnt to 16'hfffe, block 3 further pairs → drop_cnt=16'hffff; next start clears to 0.
- stop during WARMUP and during RUN with u_valid=1 → IDLE next cycle, urng_reset=1, u_valid=0; start+stop same cycle in IDLE → stays IDLE; reset asserted in RUN → all outputs reset values next cycle.
